// File: rtl/adsr_vca.sv
// adsr_vca: per-voice ADSR envelope and VCA, advanced by the oscillator step strobe.
// The VCA scales each sample by the envelope level held before that step's update.
module adsr_vca (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        step_in,
  input  logic        gate_in,
  input  logic [15:0] attack_incr,
  input  logic [15:0] decay_decr,
  input  logic [15:0] sustain_level,
  input  logic [15:0] release_decr,
  input  logic [31:0] sample_in,
  output logic [31:0] sample_out,
  output logic        valid_out,
  output logic [15:0] env_out,
  output logic [2:0]  state_out,
  output logic        busy_out
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ATTACK  = 3'd1;
  localparam logic [2:0] S_DECAY   = 3'd2;
  localparam logic [2:0] S_SUSTAIN = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_env;
  logic [31:0] r_sample;
  logic        r_valid;

  logic [2:0]  w_state_nxt;
  logic [15:0] w_env_nxt;
  logic [16:0] w_att_sum;
  logic [16:0] w_dec_diff;
  logic [16:0] w_rel_diff;
  logic [15:0] w_att_env;
  logic [15:0] w_dec_env;
  logic [15:0] w_rel_env;
  logic        w_att_top;
  logic signed [47:0] w_smp_x;
  logic signed [47:0] w_env_x;
  logic signed [47:0] w_prod;
  logic [31:0] w_scaled;
  logic        w_busy;

  // 17-bit arithmetic: bit 16 flags attack overflow or decay/release underflow
  assign w_att_sum  = {1'b0, r_env} + {1'b0, attack_incr};
  assign w_dec_diff = {1'b0, r_env} - {1'b0, decay_decr};
  assign w_rel_diff = {1'b0, r_env} - {1'b0, release_decr};

  assign w_att_env = (attack_incr == 16'd0 || w_att_sum[16]) ?
                     16'hFFFF : w_att_sum[15:0];
  assign w_dec_env = (decay_decr == 16'd0 || w_dec_diff[16] ||
                      w_dec_diff[15:0] <= sustain_level) ?
                     sustain_level : w_dec_diff[15:0];
  assign w_rel_env = (release_decr == 16'd0 || w_rel_diff[16]) ?
                     16'd0 : w_rel_diff[15:0];
  assign w_att_top = (w_att_env == 16'hFFFF);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_env    <= 16'd0;
      r_sample <= 32'd0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= step_in;
      if (step_in) begin
        r_state  <= w_state_nxt;
        r_env    <= w_env_nxt;
        r_sample <= w_scaled;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    unique case (r_state)
      S_IDLE: begin
        w_env_nxt = 16'd0;
        if (gate_in) begin
          w_env_nxt   = w_att_env;
          w_state_nxt = w_att_top ? S_DECAY : S_ATTACK;
        end
      end
      S_ATTACK: begin
        if (!gate_in) begin
          w_state_nxt = S_RELEASE;
        end else begin
          w_env_nxt   = w_att_env;
          w_state_nxt = w_att_top ? S_DECAY : S_ATTACK;
        end
      end
      S_DECAY: begin
        if (!gate_in) begin
          w_state_nxt = S_RELEASE;
        end else begin
          w_env_nxt = w_dec_env;
          if (w_dec_env == sustain_level) w_state_nxt = S_SUSTAIN;
        end
      end
      S_SUSTAIN: begin
        if (!gate_in) w_state_nxt = S_RELEASE;
        else          w_env_nxt   = sustain_level;
      end
      S_RELEASE: begin
        if (gate_in) begin
          w_env_nxt   = w_att_env;
          w_state_nxt = w_att_top ? S_DECAY : S_ATTACK;
        end else begin
          w_env_nxt = w_rel_env;
          if (w_rel_env == 16'd0) w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_env_nxt   = 16'd0;
      end
    endcase
  end

  // product fits in 48 bits signed; arithmetic shift gives floor division
  assign w_smp_x = {{16{sample_in[31]}}, sample_in};
  assign w_env_x = {32'd0, r_env};
  assign w_prod  = w_smp_x * w_env_x;

  always_comb begin
    w_scaled = 32'(w_prod >>> 16);
    w_busy   = (r_state != S_IDLE);
  end

  assign sample_out = r_sample;
  assign valid_out  = r_valid;
  assign env_out    = r_env;
  assign state_out  = r_state;
  assign busy_out   = w_busy;

endmodule

// File: tb/tb_adsr_vca.sv
// tb_adsr_vca: directed envelope scenarios then randomized steps,
// all checked against an arithmetic reference model of the envelope and VCA.
module tb_adsr_vca;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step = 1'b0;
  logic        gate = 1'b0;
  logic [15:0] a = 16'd0;
  logic [15:0] d = 16'd0;
  logic [15:0] s = 16'd0;
  logic [15:0] r = 16'd0;
  logic [31:0] smp_in = 32'd0;
  logic [31:0] smp_out;
  logic        vld;
  logic [15:0] env;
  logic [2:0]  st;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  int m_env = 0;
  int m_st  = 0;
  logic [31:0] m_out = 32'd0;

  always #5 clk = ~clk;

  adsr_vca dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .step_in       (step),
    .gate_in       (gate),
    .attack_incr   (a),
    .decay_decr    (d),
    .sustain_level (s),
    .release_decr  (r),
    .sample_in     (smp_in),
    .sample_out    (smp_out),
    .valid_out     (vld),
    .env_out       (env),
    .state_out     (st),
    .busy_out      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  task automatic m_attack();
    m_env = (a == 0) ? 65535 : imin(m_env + int'(a), 65535);
    m_st  = (m_env == 65535) ? 2 : 1;
  endtask

  // envelope rules in plain integer arithmetic; states 0..4 = I,A,D,S,R
  task automatic model_step(input bit g, input logic [31:0] x);
    longint p;
    p = longint'($signed(x)) * longint'(m_env);
    m_out = 32'(p >>> 16);
    case (m_st)
      0: if (g) m_attack(); else m_env = 0;
      1: if (!g) m_st = 4; else m_attack();
      2: if (!g) m_st = 4;
         else begin
           m_env = (d == 0) ? int'(s) : imax(m_env - int'(d), int'(s));
           if (m_env == int'(s)) m_st = 3;
         end
      3: if (!g) m_st = 4; else m_env = int'(s);
      default: if (g) m_attack();
         else begin
           m_env = (r == 0) ? 0 : imax(m_env - int'(r), 0);
           if (m_env == 0) m_st = 0;
         end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_out"}, smp_out, m_out);
    chk({tag, "_env"}, 32'(env), 32'(m_env));
    chk({tag, "_st"}, 32'(st), 32'(m_st));
    chk({tag, "_busy"}, 32'(busy), 32'(m_st != 0));
  endtask

  task automatic do_step(input string tag, input bit g, input logic [31:0] x);
    gate = g;
    smp_in = x;
    step = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step = 1'b0;
    model_step(g, x);
    chk({tag, "_vld"}, 32'(vld), 32'd1);
    check_all(tag);
  endtask

  task automatic idle_cycle(input string tag);
    step = 1'b0;
    smp_in = $urandom;
    gate = ~gate;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld0"}, 32'(vld), 32'd0);
    chk({tag, "_hold"}, 32'(env), 32'(m_env));
  endtask

  task automatic rst_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_out"}, smp_out, 32'd0);
    chk({tag, "_vld"}, 32'(vld), 32'd0);
    chk({tag, "_env"}, 32'(env), 32'd0);
    chk({tag, "_st"}, 32'(st), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_env = 0;
    m_st  = 0;
    m_out = 32'd0;
  endtask

  function automatic logic [15:0] rnd_rate();
    case ($urandom_range(0, 3))
      0:       return 16'd0;
      1:       return 16'($urandom_range(1, 255));
      2:       return 16'($urandom_range(256, 8191));
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  logic [15:0] t2_env [4] = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
  logic [2:0]  t2_st  [4] = '{3'd1, 3'd1, 3'd1, 3'd2};
  logic [15:0] t3_env [4] = '{16'hEFFF, 16'hDFFF, 16'hCFFF, 16'hC000};
  logic [15:0] t4_env [4] = '{16'hC000, 16'h8000, 16'h4000, 16'h0000};

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    rst_pulse("rst0");
    for (int i = 0; i < 2; i++) do_step("idle", 1'b0, $urandom);
    idle_cycle("gap");

    a = 16'h4000;
    for (int i = 0; i < 4; i++) begin
      do_step("att", 1'b1, $urandom);
      chk("att_env_c", 32'(env), 32'(t2_env[i]));
      chk("att_st_c", 32'(st), 32'(t2_st[i]));
    end

    d = 16'h1000;
    s = 16'hC000;
    for (int i = 0; i < 4; i++) begin
      do_step("dec", 1'b1, $urandom);
      chk("dec_env_c", 32'(env), 32'(t3_env[i]));
    end
    chk("dec_sus_c", 32'(st), 32'd3);
    s = 16'hA000;
    do_step("sus_a", 1'b1, $urandom);
    chk("sus_track_c", 32'(env), 32'hA000);
    s = 16'hC000;
    do_step("sus_c", 1'b1, $urandom);

    r = 16'h4000;
    for (int i = 0; i < 4; i++) begin
      do_step("rel", 1'b0, $urandom);
      chk("rel_env_c", 32'(env), 32'(t4_env[i]));
    end
    chk("rel_idle_c", 32'(st), 32'd0);
    chk("rel_busy_c", 32'(busy), 32'd0);

    a = 16'h8000;
    do_step("vca0", 1'b1, 32'h12345678);
    chk("vca_zero_c", smp_out, 32'd0);
    do_step("vca8", 1'b1, 32'h80000000);
    chk("vca_half_c", smp_out, 32'hC0000000);
    do_step("vcaF", 1'b1, 32'h7FFFFFFF);
    chk("vca_full_c", smp_out, 32'h7FFF7FFF);

    r = 16'hAFFF;
    do_step("rel2", 1'b0, $urandom);
    do_step("rel3", 1'b0, $urandom);
    chk("rel_4000_c", 32'(env), 32'h4000);
    a = 16'h1000;
    do_step("reatt", 1'b1, $urandom);
    chk("reatt_st_c", 32'(st), 32'd1);
    chk("reatt_env_c", 32'(env), 32'h5000);

    a = 16'd0;
    d = 16'd0;
    r = 16'd0;
    do_step("z_rel", 1'b0, $urandom);
    do_step("z_idle", 1'b0, $urandom);
    do_step("z_att", 1'b1, $urandom);
    chk("z_full_c", 32'(env), 32'hFFFF);
    do_step("z_dec", 1'b1, $urandom);
    chk("z_sus_c", 32'(env), 32'hC000);
    do_step("z_r1", 1'b0, $urandom);
    do_step("z_r2", 1'b0, $urandom);
    chk("z_zero_c", 32'(env), 32'd0);

    a = 16'h1000;
    do_step("ra1", 1'b1, $urandom);
    do_step("ra2", 1'b1, $urandom);
    rst_pulse("rst_mid");

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) a = rnd_rate();
      if ($urandom_range(0, 9) == 0) d = rnd_rate();
      if ($urandom_range(0, 9) == 0) r = rnd_rate();
      if ($urandom_range(0, 19) == 0) s = 16'($urandom);
      if ($urandom_range(0, 11) == 0) gate = ~gate;
      do_step("rnd", gate, $urandom);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        logic g_keep;
        g_keep = gate;
        idle_cycle("rnd_gap");
        gate = g_keep;
      end
      if ($urandom_range(0, 149) == 0) rst_pulse("rnd_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/adsr_vca.md
# adsr_vca

Per-voice ADSR envelope generator and voltage-controlled amplifier, one stage downstream of the per-voice oscillators (triangle, saw, etc.). It consumes the oscillator's signed 32-bit sample on the same sample strobe that advances the oscillator phase. It runs a gate-driven attack/decay/sustain/release state machine and outputs the sample scaled by the current 16-bit envelope level. The output feeds the voice mixer.

## Interface
Parameters:
- none; widths are fixed: sample 32-bit signed, envelope 16-bit unsigned (0xFFFF = full scale)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- step_in  input  1  sample strobe, same pulse that steps the oscillator; one-cycle pulse
- gate_in  input  1  note gate level (1 = key held)
- attack_incr  input  16  envelope increment per step in ATTACK; 0 = instant
- decay_decr  input  16  envelope decrement per step in DECAY; 0 = instant
- sustain_level  input  16  SUSTAIN level, tracked live
- release_decr  input  16  envelope decrement per step in RELEASE; 0 = instant
- sample_in  input  32  signed oscillator sample, stable on step_in cycles
- sample_out  output  32  signed scaled sample
- valid_out  output  1  one-cycle pulse; sample_out updated
- env_out  output  16  current envelope level
- state_out  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- busy_out  output  1  state_out != IDLE

## Operation
- State, envelope and outputs change only on cycles with step_in=1, except reset. With step_in=0 everything holds and valid_out=0.
- Gate is sampled only on step_in cycles. Gate transitions take priority over level-driven transitions in the same step.
- IDLE:
  - env=0.
  - gate_in=1 -> ATTACK; env += attack_incr, same step.
- ATTACK:
  - gate_in=0 -> RELEASE; env unchanged this step.
  - Otherwise env = min(env + attack_incr, 0xFFFF), using a 17-bit sum with saturation.
  - attack_incr=0 -> env=0xFFFF.
  - The new env reaching 0xFFFF -> DECAY.
- DECAY:
  - gate_in=0 -> RELEASE.
  - Otherwise env = max(env - decay_decr, sustain_level), with no underflow.
  - decay_decr=0 -> env=sustain_level.
  - The new env equal to sustain_level -> SUSTAIN.
  - If sustain_level >= env on entry, env is set to sustain_level and the state goes to SUSTAIN.
- SUSTAIN:
  - env=sustain_level, reloaded every step.
  - gate_in=0 -> RELEASE.
- RELEASE:
  - gate_in=1 -> ATTACK from the current env (no reset to 0); the attack increment is applied the same step.
  - Otherwise env = max(env - release_decr, 0).
  - release_decr=0 -> env=0.
  - env reaching 0 -> IDLE.
- VCA:
  - On each step_in, sample_out <= floor(sample_in * env_old / 65536), where env_old is env_out before this step's update.
  - env is zero-extended to 17 bits signed; the 49-bit signed product is taken as bits [47:16], i.e. an arithmetic shift.
  - No overflow is possible; the magnitude of sample_out never exceeds that of sample_in.
- The scaled output is computed in IDLE as well; it equals 0 whenever env_old=0.

## Timing
- All outputs are registered.
- Reset values: sample_out=0, valid_out=0, env_out=0, state_out=IDLE, busy_out=0.
- Reset takes effect immediately and asynchronously, including mid-note. Operation resumes on the first step_in after deassertion, in IDLE.
- Latency: a step_in at cycle N gives new sample_out, env_out, state_out and valid_out=1 at cycle N+1.
- valid_out is high for exactly one cycle per step_in.
- Back-to-back step_in on consecutive cycles is supported, one update per cycle.
- The envelope lags the VCA by one step: a step applies the level computed at the previous step.
- Input changes to the rate inputs or sustain_level take effect on the next step_in; nothing is latched at note-on.

## Test plan
1. Reset and hold:
   - Assert rst_in mid-cycle -> all outputs at reset values within the same cycle.
   - Release reset, apply step_in with gate=0 -> state IDLE, env 0, sample_out 0, one valid_out pulse per step.
2. Attack:
   - attack_incr=0x4000, gate=1, four steps -> env 0x4000, 0x8000, 0xC000, 0xFFFF.
   - state ATTACK, ATTACK, ATTACK, DECAY.
3. Decay to sustain:
   - decay_decr=0x1000, sustain_level=0xC000 from 0xFFFF -> env 0xEFFF, 0xDFFF, 0xCFFF, 0xC000, then state SUSTAIN.
   - Change sustain_level to 0xA000 -> env 0xA000 on the next step.
4. Release to idle:
   - From SUSTAIN at 0xC000, gate=0, release_decr=0x4000 -> env 0xC000 (state RELEASE), then 0x8000, 0x4000, 0x0000.
   - state IDLE, busy_out=0.
5. VCA arithmetic:
   - env_old=0xFFFF, sample_in=0x7FFFFFFF -> sample_out 0x7FFF7FFF.
   - env_old=0x8000, sample_in=0x80000000 -> sample_out 0xC0000000.
   - env_old=0, any sample_in -> 0.
6. Edge cases:
   - gate=1 during RELEASE at env 0x4000, attack_incr=0x1000 -> ATTACK, env 0x5000.
   - All rates 0 -> env jumps 0xFFFF, then sustain, then 0 on successive steps.
   - rst_in pulse mid-ATTACK -> IDLE/env 0 immediately.
